isr_ack_sequencer: RTL and testbench

ISR_ACK_SEQUENCER -- requirements
Module: isr_ack_sequencer

---
 rtl/isr_ack_sequencer.sv | 147 ++++++++++++++
 tb/tb_isr_ack_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isr_ack_sequencer.sv
// Interrupt acknowledge sequencer: runs the two-pulse INTA handshake, maintains the
// in-service register under fully nested priority, and applies auto/specific/non-specific EOI.
module isr_ack_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] chosen_interrupt,
    input  logic       auto_eoi,
    input  logic [4:0] vector_base,
    input  logic       INTA_n,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       INT,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [7:0] ISR,
    output logic [7:0] clear_irr
);

    // state | meaning
    // IDLE  | no request outstanding, INTA edges ignored
    // REQ   | INT asserted, waiting for first INTA falling edge
    // ACK1  | first INTA pulse low, level latched
    // GAP   | between the two INTA pulses
    // ACK2  | second INTA pulse low, vector driven
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        ACK1 = 3'd2,
        GAP  = 3'd3,
        ACK2 = 3'd4
    } state_t;

    state_t     state, state_next;
    logic       inta_q;
    logic       inta_fall, inta_rise;
    logic [2:0] level, level_next;
    logic       spurious, spurious_next;
    logic       int_next;
    logic       oe_next;
    logic [7:0] dout_next;
    logic [7:0] clr_irr_next;
    logic [7:0] isr_set, isr_auto_clr, isr_eoi_clr, isr_next;
    logic       eligible;

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign inta_fall = inta_q & ~INTA_n;
    assign inta_rise = ~inta_q & INTA_n;
    assign eligible  = (chosen_interrupt != 8'd0) &&
                       ((ISR == 8'd0) || (lowest_idx(chosen_interrupt) < lowest_idx(ISR)));

    always_comb begin
        state_next    = state;
        level_next    = level;
        spurious_next = spurious;
        isr_set       = 8'd0;
        isr_auto_clr  = 8'd0;
        clr_irr_next  = 8'd0;
        oe_next       = 1'b0;
        dout_next     = 8'd0;
        case (state)
            IDLE: begin
                if (eligible) state_next = REQ;
            end
            REQ: begin
                if (inta_fall) begin
                    state_next = ACK1;
                    if (chosen_interrupt != 8'd0) begin
                        level_next    = lowest_idx(chosen_interrupt);
                        spurious_next = 1'b0;
                        isr_set       = 8'b1 << lowest_idx(chosen_interrupt);
                        clr_irr_next  = 8'b1 << lowest_idx(chosen_interrupt);
                    end else begin
                        level_next    = 3'd7;
                        spurious_next = 1'b1;
                    end
                end else if (chosen_interrupt == 8'd0) begin
                    state_next = IDLE;
                end
            end
            ACK1: begin
                if (inta_rise) state_next = GAP;
            end
            GAP: begin
                if (inta_fall) begin
                    state_next = ACK2;
                    oe_next    = 1'b1;
                    dout_next  = {vector_base, level};
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    state_next = IDLE;
                    if (auto_eoi && !spurious) isr_auto_clr = 8'b1 << level;
                end else begin
                    oe_next   = 1'b1;
                    dout_next = {vector_base, level};
                end
            end
            default: state_next = IDLE;
        endcase
        int_next = (state_next == REQ);
    end

    always_comb begin
        isr_eoi_clr = 8'd0;
        if (eoi_valid) begin
            if (eoi_specific)    isr_eoi_clr = 8'b1 << eoi_level;
            else if (ISR != 8'd0) isr_eoi_clr = 8'b1 << lowest_idx(ISR);
        end
        // a set on the same bit as a clear wins
        isr_next = (ISR & ~(isr_eoi_clr | isr_auto_clr)) | isr_set;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            inta_q    <= 1'b1;
            level     <= 3'd0;
            spurious  <= 1'b0;
            INT       <= 1'b0;
            data_out  <= 8'd0;
            data_oe   <= 1'b0;
            ISR       <= 8'd0;
            clear_irr <= 8'd0;
        end else begin
            state     <= state_next;
            inta_q    <= INTA_n;
            level     <= level_next;
            spurious  <= spurious_next;
            INT       <= int_next;
            data_out  <= dout_next;
            data_oe   <= oe_next;
            ISR       <= isr_next;
            clear_irr <= clr_irr_next;
        end
    end

endmodule

// File: tb/tb_isr_ack_sequencer.sv
// Self-checking bench for isr_ack_sequencer: directed scenarios plus randomized
// acknowledge/EOI traffic checked against a behavioural ISR model.
module tb_isr_ack_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] chosen_interrupt = 8'd0;
    logic       auto_eoi = 1'b0;
    logic [4:0] vector_base = 5'd0;
    logic       INTA_n = 1'b1;
    logic       eoi_valid = 1'b0;
    logic       eoi_specific = 1'b0;
    logic [2:0] eoi_level = 3'd0;
    logic       INT;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] ISR;
    logic [7:0] clear_irr;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] prev_clr = 8'd0;

    isr_ack_sequencer dut (
        .clk(clk), .reset_n(reset_n), .chosen_interrupt(chosen_interrupt),
        .auto_eoi(auto_eoi), .vector_base(vector_base), .INTA_n(INTA_n),
        .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
        .INT(INT), .data_out(data_out), .data_oe(data_oe), .ISR(ISR), .clear_irr(clear_irr)
    );

    always #5 clk = ~clk;

    // continuous invariants on the pulse and bus outputs
    always @(negedge clk) begin
        if (reset_n) begin
            n_cmp++;
            if ((clear_irr & (clear_irr - 8'd1)) !== 8'd0) begin
                n_err++; $display("FAIL clr_onehot got=%h exp=zero_or_onehot", clear_irr);
            end
            n_cmp++;
            if (prev_clr != 8'd0 && clear_irr !== 8'd0) begin
                n_err++; $display("FAIL clr_consecutive got=%h prev=%h exp=00", clear_irr, prev_clr);
            end
            if (data_oe === 1'b0) begin
                n_cmp++;
                if (data_out !== 8'd0) begin
                    n_err++; $display("FAIL dout_idle got=%h exp=00", data_out);
                end
            end
        end
        prev_clr = clear_irr;
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic reset_seq;
        reset_n = 1'b0; chosen_interrupt = 8'd0; auto_eoi = 1'b0; INTA_n = 1'b1;
        eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
        tick; tick;
        reset_n = 1'b1;
    endtask

    task automatic drive_full_ack(input logic [7:0] ch, input logic ae);
        chosen_interrupt = ch; auto_eoi = ae; tick;
        INTA_n = 1'b0; tick; tick;
        INTA_n = 1'b1; tick;
        INTA_n = 1'b0; tick; tick;
        chosen_interrupt = 8'd0; INTA_n = 1'b1; tick;
        auto_eoi = 1'b0;
    endtask

    function automatic logic model_eligible(input logic [7:0] ch, input logic [7:0] isr);
        logic [7:0] lowest_bit;
        lowest_bit = isr & (~isr + 8'd1);
        return (ch != 8'd0) && (isr == 8'd0 || ch < lowest_bit);
    endfunction

    task automatic test_reset;
        reset_n = 1'b0; chosen_interrupt = 8'h01; tick; tick;
        n_cmp++; if (INT !== 1'b0) begin n_err++; $display("FAIL reset_int got=%b exp=0", INT); end
        n_cmp++; if (ISR !== 8'h00) begin n_err++; $display("FAIL reset_isr got=%h exp=00", ISR); end
        n_cmp++; if (data_oe !== 1'b0 || data_out !== 8'h00) begin
            n_err++; $display("FAIL reset_bus got=%b/%h exp=0/00", data_oe, data_out); end
        n_cmp++; if (clear_irr !== 8'h00) begin n_err++; $display("FAIL reset_clr got=%h exp=00", clear_irr); end
        reset_seq;
    endtask

    task automatic test_basic;
        reset_seq;
        vector_base = 5'b01000; chosen_interrupt = 8'h08; tick;
        n_cmp++; if (INT !== 1'b1) begin n_err++; $display("FAIL basic_int got=%b exp=1", INT); end
        INTA_n = 1'b0; tick;
        n_cmp++; if (INT !== 1'b0) begin n_err++; $display("FAIL basic_int_drop got=%b exp=0", INT); end
        n_cmp++; if (ISR !== 8'h08) begin n_err++; $display("FAIL basic_isr got=%h exp=08", ISR); end
        n_cmp++; if (clear_irr !== 8'h08) begin n_err++; $display("FAIL basic_clr got=%h exp=08", clear_irr); end
        tick;
        n_cmp++; if (clear_irr !== 8'h00) begin n_err++; $display("FAIL basic_clr_end got=%h exp=00", clear_irr); end
        INTA_n = 1'b1; tick;
        n_cmp++; if (data_oe !== 1'b0) begin n_err++; $display("FAIL basic_gap_oe got=%b exp=0", data_oe); end
        INTA_n = 1'b0; tick;
        n_cmp++; if (data_oe !== 1'b1 || data_out !== 8'h43) begin
            n_err++; $display("FAIL basic_vector got=%b/%h exp=1/43", data_oe, data_out); end
        tick;
        n_cmp++; if (data_oe !== 1'b1 || data_out !== 8'h43) begin
            n_err++; $display("FAIL basic_vector_hold got=%b/%h exp=1/43", data_oe, data_out); end
        chosen_interrupt = 8'd0; INTA_n = 1'b1; tick;
        n_cmp++; if (data_oe !== 1'b0 || ISR !== 8'h08) begin
            n_err++; $display("FAIL basic_end got=%b/%h exp=0/08", data_oe, ISR); end
    endtask

    task automatic test_auto_eoi;
        reset_seq;
        auto_eoi = 1'b1; chosen_interrupt = 8'h01; tick;
        INTA_n = 1'b0; tick; tick;
        n_cmp++; if (ISR !== 8'h01) begin n_err++; $display("FAIL aeoi_set got=%h exp=01", ISR); end
        INTA_n = 1'b1; tick;
        INTA_n = 1'b0; tick; tick;
        n_cmp++; if (ISR !== 8'h01 || data_oe !== 1'b1) begin
            n_err++; $display("FAIL aeoi_ack2 got=%h/%b exp=01/1", ISR, data_oe); end
        chosen_interrupt = 8'd0; INTA_n = 1'b1; tick;
        n_cmp++; if (ISR !== 8'h00) begin n_err++; $display("FAIL aeoi_clear got=%h exp=00", ISR); end
        auto_eoi = 1'b0;
    endtask

    task automatic test_nesting;
        reset_seq;
        vector_base = 5'b00110;
        drive_full_ack(8'h10, 1'b0);
        n_cmp++; if (ISR !== 8'h10) begin n_err++; $display("FAIL nest_pre got=%h exp=10", ISR); end
        chosen_interrupt = 8'h20; tick; tick;
        n_cmp++; if (INT !== 1'b0) begin n_err++; $display("FAIL nest_blocked got=%b exp=0", INT); end
        chosen_interrupt = 8'h02; tick;
        n_cmp++; if (INT !== 1'b1) begin n_err++; $display("FAIL nest_int got=%b exp=1", INT); end
        INTA_n = 1'b0; tick;
        n_cmp++; if (ISR !== 8'h12) begin n_err++; $display("FAIL nest_isr got=%h exp=12", ISR); end
        INTA_n = 1'b1; tick;
        INTA_n = 1'b0; tick;
        n_cmp++; if (data_out !== 8'h31) begin n_err++; $display("FAIL nest_vector got=%h exp=31", data_out); end
        chosen_interrupt = 8'd0; INTA_n = 1'b1; tick;
        eoi_valid = 1'b1; eoi_specific = 1'b0; tick;
        eoi_valid = 1'b0;
        n_cmp++; if (ISR !== 8'h10) begin n_err++; $display("FAIL nest_nseoi got=%h exp=10", ISR); end
        eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd4; tick;
        eoi_valid = 1'b0;
        n_cmp++; if (ISR !== 8'h00) begin n_err++; $display("FAIL nest_seoi got=%h exp=00", ISR); end
        eoi_valid = 1'b1; eoi_specific = 1'b0; tick;
        eoi_valid = 1'b0;
        n_cmp++; if (ISR !== 8'h00) begin n_err++; $display("FAIL nest_nseoi_empty got=%h exp=00", ISR); end
    endtask

    task automatic test_spurious;
        reset_seq;
        vector_base = 5'b10101;
        drive_full_ack(8'h80, 1'b0);
        auto_eoi = 1'b1; chosen_interrupt = 8'h01; tick;
        n_cmp++; if (INT !== 1'b1) begin n_err++; $display("FAIL spur_int got=%b exp=1", INT); end
        chosen_interrupt = 8'h00; INTA_n = 1'b0; tick;
        n_cmp++; if (ISR !== 8'h80 || clear_irr !== 8'h00) begin
            n_err++; $display("FAIL spur_ack1 got=%h/%h exp=80/00", ISR, clear_irr); end
        tick; INTA_n = 1'b1; tick;
        INTA_n = 1'b0; tick;
        n_cmp++; if (data_oe !== 1'b1 || data_out !== 8'hAF) begin
            n_err++; $display("FAIL spur_vector got=%b/%h exp=1/af", data_oe, data_out); end
        INTA_n = 1'b1; tick;
        n_cmp++; if (ISR !== 8'h80 || data_oe !== 1'b0) begin
            n_err++; $display("FAIL spur_end got=%h/%b exp=80/0", ISR, data_oe); end
        auto_eoi = 1'b0;
    endtask

    task automatic test_withdraw;
        reset_seq;
        chosen_interrupt = 8'h40; tick;
        n_cmp++; if (INT !== 1'b1) begin n_err++; $display("FAIL wd_int got=%b exp=1", INT); end
        chosen_interrupt = 8'h00; tick;
        n_cmp++; if (INT !== 1'b0) begin n_err++; $display("FAIL wd_drop got=%b exp=0", INT); end
        INTA_n = 1'b0; tick; INTA_n = 1'b1; tick; INTA_n = 1'b0; tick; tick;
        n_cmp++; if (ISR !== 8'h00 || data_oe !== 1'b0) begin
            n_err++; $display("FAIL wd_ignored got=%h/%b exp=00/0", ISR, data_oe); end
        INTA_n = 1'b1; tick;
    endtask

    task automatic test_reset_mid_ack2;
        reset_seq;
        vector_base = 5'b11100; chosen_interrupt = 8'h04; tick;
        INTA_n = 1'b0; tick; tick;
        INTA_n = 1'b1; tick;
        INTA_n = 1'b0; tick;
        n_cmp++; if (data_oe !== 1'b1) begin n_err++; $display("FAIL rst2_pre got=%b exp=1", data_oe); end
        reset_n = 1'b0; chosen_interrupt = 8'h00; INTA_n = 1'b1; eoi_valid = 1'b1; tick;
        eoi_valid = 1'b0;
        n_cmp++; if (data_oe !== 1'b0 || ISR !== 8'h00 || INT !== 1'b0) begin
            n_err++; $display("FAIL rst2_abort got=%b/%h/%b exp=0/00/0", data_oe, ISR, INT); end
        reset_n = 1'b1; tick;
        INTA_n = 1'b0; tick; tick;
        n_cmp++; if (data_oe !== 1'b0 || INT !== 1'b0) begin
            n_err++; $display("FAIL rst2_inta1 got=%b/%b exp=0/0", data_oe, INT); end
        INTA_n = 1'b1; tick; INTA_n = 1'b0; tick; tick;
        n_cmp++; if (data_oe !== 1'b0 || ISR !== 8'h00) begin
            n_err++; $display("FAIL rst2_inta2 got=%b/%h exp=0/00", data_oe, ISR); end
        INTA_n = 1'b1; tick;
    endtask

    task automatic test_collision;
        reset_seq;
        chosen_interrupt = 8'h08; tick;
        INTA_n = 1'b0; eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3; tick;
        eoi_valid = 1'b0;
        n_cmp++; if (ISR !== 8'h08) begin n_err++; $display("FAIL coll_same got=%h exp=08", ISR); end
        tick; INTA_n = 1'b1; tick; INTA_n = 1'b0; tick; tick;
        chosen_interrupt = 8'h00; INTA_n = 1'b1; tick;
        drive_full_ack(8'h20, 1'b0);
        chosen_interrupt = 8'h02; tick;
        INTA_n = 1'b0; eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd5; tick;
        eoi_valid = 1'b0;
        n_cmp++; if (ISR !== 8'h0A) begin n_err++; $display("FAIL coll_diff got=%h exp=0a", ISR); end
        tick; INTA_n = 1'b1; tick; INTA_n = 1'b0; tick; tick;
        chosen_interrupt = 8'h00; INTA_n = 1'b1; tick;
    endtask

    task automatic test_random;
        logic [7:0] isr_m;
        logic [7:0] ch;
        logic [2:0] lvl;
        logic [2:0] el;
        logic [4:0] vb;
        logic       ae, sp, elig;
        reset_seq;
        isr_m = 8'd0;
        for (int it = 0; it < 60; it++) begin
            vb  = 5'($urandom);
            lvl = 3'($urandom_range(0, 7));
            ch  = ($urandom_range(0, 4) == 0) ? 8'd0 : (8'd1 << lvl);
            ae  = 1'($urandom_range(0, 1));
            vector_base = vb; chosen_interrupt = ch; auto_eoi = ae; tick;
            elig = model_eligible(ch, isr_m);
            n_cmp++; if (INT !== elig) begin
                n_err++; $display("FAIL rnd_int it=%0d got=%b exp=%b", it, INT, elig); end
            if (elig) begin
                INTA_n = 1'b0; tick;
                isr_m = isr_m | ch;
                n_cmp++; if (ISR !== isr_m || clear_irr !== ch) begin
                    n_err++; $display("FAIL rnd_ack1 it=%0d got=%h/%h exp=%h/%h", it, ISR, clear_irr, isr_m, ch); end
                tick; INTA_n = 1'b1; tick;
                INTA_n = 1'b0; tick;
                n_cmp++; if (data_oe !== 1'b1 || data_out !== {vb, lvl}) begin
                    n_err++; $display("FAIL rnd_vector it=%0d got=%b/%h exp=1/%h", it, data_oe, data_out, {vb, lvl}); end
                chosen_interrupt = 8'd0; INTA_n = 1'b1; tick;
                if (ae) isr_m = isr_m & ~ch;
                n_cmp++; if (ISR !== isr_m || data_oe !== 1'b0) begin
                    n_err++; $display("FAIL rnd_end it=%0d got=%h/%b exp=%h/0", it, ISR, data_oe, isr_m); end
            end else begin
                chosen_interrupt = 8'd0; tick;
            end
            if ($urandom_range(0, 2) == 0) begin
                sp = 1'($urandom_range(0, 1));
                el = 3'($urandom_range(0, 7));
                eoi_valid = 1'b1; eoi_specific = sp; eoi_level = el; tick;
                eoi_valid = 1'b0;
                if (sp) isr_m[el] = 1'b0;
                else    isr_m = isr_m & (isr_m - 8'd1);
                n_cmp++; if (ISR !== isr_m) begin
                    n_err++; $display("FAIL rnd_eoi it=%0d sp=%b lvl=%0d got=%h exp=%h", it, sp, el, ISR, isr_m); end
            end
        end
        auto_eoi = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_auto_eoi;
        test_nesting;
        test_spurious;
        test_withdraw;
        test_reset_mid_ack2;
        test_collision;
        test_random;
        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
